// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU/ResultSrc codes, immediate formats.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J} imm_src_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    imm_src_e   imm_src;
  } ctrl_t;

  // Sign-extends the immediate for the selected format; R-type and bubbles give 0.
  function automatic logic signed [31:0] imm_ext(input logic [31:0] instr, input imm_src_e src);
    logic signed [31:0] imm;
    case (src)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file, x0 hardwired to zero, synchronous clear.
// Optional same-cycle write-through when ID_BYPASS_EN is defined.
module regfile
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] mem [32];

  // Reset wins over a coincident write; x0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      mem[wa] <= wd;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [4:0] ra);
    logic [DATA_W-1:0] val;
    if (ra == 5'd0) begin
      val = '0;
`ifdef ID_BYPASS_EN
    end else if (!reset && we && (wa == ra)) begin
      val = wd;
`endif
    end else begin
      val = mem[ra];
    end
    return val;
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: zero-latency decoder, immediate extender and register file.
// Build macro ID_BYPASS_EN enables register-file write-through.
module id_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic        RegWriteD,
  output logic        MemWriteD,
  output logic        JumpD,
  output logic        BranchD,
  output logic        ALUSrcD,
  output logic [1:0]  ResultSrcD,
  output logic [2:0]  ALUControlD,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic [31:0] ImmExtD,
  output logic [31:0] PCD_o,
  output logic [31:0] PCPlus4D_o,
  output logic [4:0]  RdD,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic        IllegalD
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  ctrl_t      ctrl;
  logic       illegal;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];
  assign RdD    = InstrD[11:7];
  assign PCD_o      = PCD;
  assign PCPlus4D_o = PCPlus4D;

  function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub, output logic bad);
    logic [2:0] op;
    bad = 1'b0;
    case (f3)
      3'b000:  op = sub ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      3'b010:  op = ALU_SLT;
      default: begin op = ALU_ADD; bad = 1'b1; end
    endcase
    return op;
  endfunction

  always_comb begin
    logic bad_f3;
    ctrl    = '0;
    illegal = 1'b0;
    bad_f3  = 1'b0;
    case (opcode)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.imm_src    = IMM_I;
        illegal         = (funct3 != 3'b010);
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_S;
        illegal        = (funct3 != 3'b010);
      end
      OP_RTYPE: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = alu_op(funct3, InstrD[30], bad_f3);
        illegal          = bad_f3;
      end
      OP_IALU: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.imm_src     = IMM_I;
        ctrl.alu_control = alu_op(funct3, 1'b0, bad_f3);
        illegal          = bad_f3;
      end
      OP_BRANCH: begin
        ctrl.branch      = 1'b1;
        ctrl.imm_src     = IMM_B;
        ctrl.alu_control = ALU_SUB;
        illegal          = (funct3 != 3'b000);
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.imm_src    = IMM_J;
      end
      default: illegal = 1'b1;
    endcase
    // Unsupported encodings become a bubble so nothing downstream commits.
    if (illegal) ctrl = '0;
  end

  assign RegWriteD   = ctrl.reg_write;
  assign MemWriteD   = ctrl.mem_write;
  assign JumpD       = ctrl.jump;
  assign BranchD     = ctrl.branch;
  assign ALUSrcD     = ctrl.alu_src;
  assign ResultSrcD  = ctrl.result_src;
  assign ALUControlD = ctrl.alu_control;
  assign IllegalD    = illegal;
  assign ImmExtD     = imm_ext(InstrD, ctrl.imm_src);

  regfile #(.DATA_W(32)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (RegWriteW),
    .wa    (RdW),
    .wd    (ResultW),
    .ra1   (Rs1D),
    .ra2   (Rs2D),
    .rd1   (RD1D),
    .rd2   (RD2D)
  );

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode vector table plus register-file sequences.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, IllegalD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD_o, PCPlus4D_o;
  logic [4:0]  RdD, Rs1D, Rs2D;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD_o(PCD_o), .PCPlus4D_o(PCPlus4D_o),
    .RdD(RdD), .Rs1D(Rs1D), .Rs2D(Rs2D), .IllegalD(IllegalD)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        regw, memw, jump, branch, alusrc;
    logic [1:0]  rsrc;
    logic [2:0]  aluc;
    logic [31:0] imm;
    logic        ill;
    logic        chk_imm;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd_instr(input logic [4:0] r1, input logic [4:0] r2);
    return {7'b0, r2, r1, 3'b000, 5'd0, 7'b0110011};
  endfunction

  function automatic vec_t mk(input string n, input logic [31:0] i, input logic rw, input logic mw,
                              input logic j, input logic b, input logic as, input logic [1:0] rs,
                              input logic [2:0] ac, input logic [31:0] im, input logic il,
                              input logic ci);
    vec_t v;
    v.name = n; v.instr = i; v.regw = rw; v.memw = mw; v.jump = j; v.branch = b;
    v.alusrc = as; v.rsrc = rs; v.aluc = ac; v.imm = im; v.ill = il; v.chk_imm = ci;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk("add",    32'h002081B3, 1,0,0,0,0, 2'b00, 3'b000, 32'h0,        0, 1);
    vecs[1]  = mk("sub",    32'h402081B3, 1,0,0,0,0, 2'b00, 3'b001, 32'h0,        0, 1);
    vecs[2]  = mk("and",    32'h0020F1B3, 1,0,0,0,0, 2'b00, 3'b010, 32'h0,        0, 1);
    vecs[3]  = mk("or",     32'h0020E1B3, 1,0,0,0,0, 2'b00, 3'b011, 32'h0,        0, 1);
    vecs[4]  = mk("slt",    32'h0020A1B3, 1,0,0,0,0, 2'b00, 3'b101, 32'h0,        0, 1);
    vecs[5]  = mk("lw",     32'hFFC12283, 1,0,0,0,1, 2'b01, 3'b000, 32'hFFFFFFFC, 0, 1);
    vecs[6]  = mk("sw",     32'h00612423, 0,1,0,0,1, 2'b00, 3'b000, 32'h00000008, 0, 1);
    vecs[7]  = mk("addi",   32'hFFF00093, 1,0,0,0,1, 2'b00, 3'b000, 32'hFFFFFFFF, 0, 1);
    vecs[8]  = mk("ori",    32'h7FF0E093, 1,0,0,0,1, 2'b00, 3'b011, 32'h000007FF, 0, 1);
    vecs[9]  = mk("beq",    32'hFE000CE3, 0,0,0,1,0, 2'b00, 3'b001, 32'hFFFFFFF8, 0, 1);
    vecs[10] = mk("jal",    32'h001000EF, 1,0,1,0,0, 2'b10, 3'b000, 32'h00000800, 0, 1);
    vecs[11] = mk("op7f",   32'h0000007F, 0,0,0,0,0, 2'b00, 3'b000, 32'h0,        1, 0);
    vecs[12] = mk("r_f3_1", 32'h002091B3, 0,0,0,0,0, 2'b00, 3'b000, 32'h0,        1, 0);
    vecs[13] = mk("i_f3_1", 32'h00109093, 0,0,0,0,0, 2'b00, 3'b000, 32'h0,        1, 0);
    vecs[14] = mk("lw_f3",  32'hFFC10283, 0,0,0,0,0, 2'b00, 3'b000, 32'h0,        1, 0);

    reset = 1'b1; InstrD = 32'h0; PCD = 32'h0; PCPlus4D = 32'h4;
    RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'h0;
    tick();
    reset = 1'b0;
    tick();

    // every register reads zero after reset
    for (int i = 0; i < 32; i++) begin
      InstrD = rd_instr(5'(i), 5'(31 - i));
      #1;
      check($sformatf("rst_rd1_x%0d", i), RD1D, 32'h0);
      check($sformatf("rst_rd2_x%0d", 31 - i), RD2D, 32'h0);
    end

    // decode table (register file still all zero)
    for (int k = 0; k < 15; k++) begin
      InstrD   = vecs[k].instr;
      PCD      = 32'h1000 + 32'(k * 4);
      PCPlus4D = 32'h1004 + 32'(k * 4);
      #1;
      check({vecs[k].name, "_regw"},   32'(RegWriteD),   32'(vecs[k].regw));
      check({vecs[k].name, "_memw"},   32'(MemWriteD),   32'(vecs[k].memw));
      check({vecs[k].name, "_jump"},   32'(JumpD),       32'(vecs[k].jump));
      check({vecs[k].name, "_branch"}, 32'(BranchD),     32'(vecs[k].branch));
      check({vecs[k].name, "_alusrc"}, 32'(ALUSrcD),     32'(vecs[k].alusrc));
      check({vecs[k].name, "_rsrc"},   32'(ResultSrcD),  32'(vecs[k].rsrc));
      check({vecs[k].name, "_aluc"},   32'(ALUControlD), 32'(vecs[k].aluc));
      check({vecs[k].name, "_ill"},    32'(IllegalD),    32'(vecs[k].ill));
      if (vecs[k].chk_imm) check({vecs[k].name, "_imm"}, ImmExtD, vecs[k].imm);
      check({vecs[k].name, "_rd"},  32'(RdD),  32'(vecs[k].instr[11:7]));
      check({vecs[k].name, "_rs1"}, 32'(Rs1D), 32'(vecs[k].instr[19:15]));
      check({vecs[k].name, "_rs2"}, 32'(Rs2D), 32'(vecs[k].instr[24:20]));
      check({vecs[k].name, "_pc"},  PCD_o,      32'h1000 + 32'(k * 4));
      check({vecs[k].name, "_pc4"}, PCPlus4D_o, 32'h1004 + 32'(k * 4));
      check({vecs[k].name, "_rd1"}, RD1D, 32'h0);
    end

    // write x5 while reading it: same-cycle value depends on write-through
    InstrD = rd_instr(5'd5, 5'd5);
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEADBEEF;
    #1;
`ifdef ID_BYPASS_EN
    check("wr_same_rd1", RD1D, 32'hDEADBEEF);
    check("wr_same_rd2", RD2D, 32'hDEADBEEF);
`else
    check("wr_same_rd1", RD1D, 32'h0);
    check("wr_same_rd2", RD2D, 32'h0);
`endif
    tick();
    RegWriteW = 1'b0; ResultW = 32'h0;
    #1;
    check("wr_next_rd1", RD1D, 32'hDEADBEEF);
    check("wr_next_rd2", RD2D, 32'hDEADBEEF);

    // second register, confirm x5 unaffected
    RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'h0BADF00D;
    tick();
    RegWriteW = 1'b0;
    InstrD = rd_instr(5'd9, 5'd5);
    #1;
    check("x9_rd1", RD1D, 32'h0BADF00D);
    check("x5_rd2", RD2D, 32'hDEADBEEF);

    // writes to x0 are discarded, no bypass for x0 either
    InstrD = rd_instr(5'd0, 5'd0);
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h1234;
    #1;
    check("x0_same", RD1D, 32'h0);
    tick();
    RegWriteW = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("x0_after_%0d_rd1", c), RD1D, 32'h0);
      check($sformatf("x0_after_%0d_rd2", c), RD2D, 32'h0);
      tick();
    end

    // reset beats a coincident write; no bypass while reset is high
    reset = 1'b1;
    RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'hFF;
    InstrD = rd_instr(5'd7, 5'd7);
    #1;
    check("rst_bypass_x7", RD1D, 32'h0);
    tick();
    reset = 1'b0; RegWriteW = 1'b0; ResultW = 32'h0;
    #1;
    check("rst_prio_x7", RD1D, 32'h0);
    InstrD = rd_instr(5'd5, 5'd9);
    #1;
    check("rst_clr_x5", RD1D, 32'h0);
    check("rst_clr_x9", RD2D, 32'h0);

    // control outputs are unaffected by reset: add still decodes
    reset = 1'b1;
    InstrD = 32'h002081B3;
    #1;
    check("rst_add_regw", 32'(RegWriteD), 32'h1);
    check("rst_add_rd",   32'(RdD),       32'h3);
    tick();
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
